// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: pipelined conditional-branch resolver.
// Compares two WIDTH-bit operands (signed or unsigned) or one operand against
// zero, and registers the taken/not-taken result after 1 or 2 stages.
// Saturating counters track how many results retired and how many were taken.
//
// Handshake: an entry is accepted on a clk edge with in_valid=1, stall=0,
// flush=0. A result is retired on a clk edge with out_valid=1 and stall=0.
// That includes an edge where flush=1. stall freezes every stage register.
// flush clears every valid bit and wins over both stall and in_valid.
module branch_cmp_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    input  logic             Uns,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             Br,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Compare-code encodings
    localparam logic [3:0] OP_LT  = 4'b0001;
    localparam logic [3:0] OP_LE  = 4'b0010;
    localparam logic [3:0] OP_EQ  = 4'b0011;
    localparam logic [3:0] OP_NE  = 4'b0100;
    localparam logic [3:0] OP_GE  = 4'b0101;
    localparam logic [3:0] OP_GT  = 4'b0110;
    localparam logic [3:0] OP_LTZ = 4'b0111;
    localparam logic [3:0] OP_GEZ = 4'b1000;
    localparam logic [3:0] OP_LEZ = 4'b1001;
    localparam logic [3:0] OP_GTZ = 4'b1010;

    // Turn the raw compare flags into a taken decision. The zero forms use
    // only the A sign bit and A==0, so they are always signed.
    function automatic logic resolve(
        input logic       eq,
        input logic       slt,
        input logic       ult,
        input logic       sign,
        input logic       zero,
        input logic [3:0] op,
        input logic       uns
    );
        logic lt;
        lt = uns ? ult : slt;
        case (op)
            OP_LT:   resolve = lt;
            OP_LE:   resolve = lt | eq;
            OP_EQ:   resolve = eq;
            OP_NE:   resolve = ~eq;
            OP_GE:   resolve = ~lt;
            OP_GT:   resolve = ~(lt | eq);
            OP_LTZ:  resolve = sign;
            OP_GEZ:  resolve = ~sign;
            OP_LEZ:  resolve = sign | zero;
            OP_GTZ:  resolve = ~(sign | zero);
            default: resolve = 1'b0;
        endcase
    endfunction

    // Raw compare flags from the incoming operands
    logic w_eq, w_slt, w_ult, w_sign, w_zero;
    assign w_eq   = (A == B);
    assign w_slt  = ($signed(A) < $signed(B));
    assign w_ult  = (A < B);
    assign w_sign = A[WIDTH-1];
    assign w_zero = (A == '0);

    logic r_out_valid;
    logic r_br;
    logic [CNT_W-1:0] r_eval_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic w_retire;

    assign w_retire = r_out_valid & ~stall;

    generate
        if (STAGES == 1) begin : g_one
            // Single stage: resolve straight from the operands into the output register
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out_valid <= 1'b0;
                    r_br        <= 1'b0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                    r_br        <= 1'b0;
                end else if (!stall) begin
                    r_out_valid <= in_valid;
                    r_br        <= in_valid &
                                   resolve(w_eq, w_slt, w_ult, w_sign, w_zero, Op, Uns);
                end
            end
        end else if (STAGES == 2) begin : g_two
            logic       r_s1_valid;
            logic       r_s1_eq;
            logic       r_s1_slt;
            logic       r_s1_ult;
            logic       r_s1_sign;
            logic       r_s1_zero;
            logic [3:0] r_s1_op;
            logic       r_s1_uns;

            // Valid bits for both stages plus the resolved output
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1_valid  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_br        <= 1'b0;
                end else if (flush) begin
                    r_s1_valid  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_br        <= 1'b0;
                end else if (!stall) begin
                    r_s1_valid  <= in_valid;
                    r_out_valid <= r_s1_valid;
                    r_br        <= r_s1_valid &
                                   resolve(r_s1_eq, r_s1_slt, r_s1_ult, r_s1_sign,
                                           r_s1_zero, r_s1_op, r_s1_uns);
                end
            end

            // Stage-1 flag payload; its value is irrelevant while r_s1_valid=0
            always_ff @(posedge clk) begin
                if (!stall) begin
                    r_s1_eq   <= w_eq;
                    r_s1_slt  <= w_slt;
                    r_s1_ult  <= w_ult;
                    r_s1_sign <= w_sign;
                    r_s1_zero <= w_zero;
                    r_s1_op   <= Op;
                    r_s1_uns  <= Uns;
                end
            end
        end else begin : g_bad
            $error("branch_cmp_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    // Saturating performance counters; clear wins over a same-edge retire
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eval_cnt  <= '0;
            r_taken_cnt <= '0;
        end else if (cnt_clr) begin
            r_eval_cnt  <= '0;
            r_taken_cnt <= '0;
        end else if (w_retire) begin
            if (r_eval_cnt != CNT_MAX) begin
                r_eval_cnt <= r_eval_cnt + CNT_ONE;
            end
            if (r_br && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + CNT_ONE;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Br        = r_br;
    assign eval_cnt  = r_eval_cnt;
    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb_branch_cmp_pipe: directed bench for branch_cmp_pipe. Three instances
// share one input bus: 1-stage, 2-stage, and 1-stage with 4-bit counters.
module tb_branch_cmp_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        uns;
    logic        cnt_clr;

    logic        d1_valid, d1_br;
    logic [15:0] d1_eval, d1_taken;
    logic        d2_valid, d2_br;
    logic [15:0] d2_eval, d2_taken;
    logic        d3_valid, d3_br;
    logic [3:0]  d3_eval, d3_taken;

    int n_checks;
    int n_errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .A(a), .B(b), .Op(op), .Uns(uns), .cnt_clr(cnt_clr),
        .out_valid(d1_valid), .Br(d1_br), .eval_cnt(d1_eval), .taken_cnt(d1_taken)
    );

    branch_cmp_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .A(a), .B(b), .Op(op), .Uns(uns), .cnt_clr(cnt_clr),
        .out_valid(d2_valid), .Br(d2_br), .eval_cnt(d2_eval), .taken_cnt(d2_taken)
    );

    branch_cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .A(a), .B(b), .Op(op), .Uns(uns), .cnt_clr(cnt_clr),
        .out_valid(d3_valid), .Br(d3_br), .eval_cnt(d3_eval), .taken_cnt(d3_taken)
    );

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic [3:0] opv, input logic uv);
        in_valid = v;
        a        = av;
        b        = bv;
        op       = opv;
        uns      = uv;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
    endtask

    // Advance one edge, then settle 1ns past it before any sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] av;
        logic [31:0] bv;
        logic [3:0]  opv;
        logic        uv;
        logic        exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int exp_taken;
        n_checks = 0;
        n_errors = 0;
        stall    = 1'b0;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
        idle();

        // ---------------- reset state ----------------
        do_reset();
        check("rst_d1_valid", {31'd0, d1_valid}, 32'd0);
        check("rst_d2_valid", {31'd0, d2_valid}, 32'd0);
        check("rst_d1_br", {31'd0, d1_br}, 32'd0);
        check("rst_d1_eval", {16'd0, d1_eval}, 32'd0);
        check("rst_d2_taken", {16'd0, d2_taken}, 32'd0);

        // ---------------- 1: signed vs unsigned, 1 stage ----------------
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0001, 1'b0);
        tick();
        check("t1_valid", {31'd0, d1_valid}, 32'd1);
        check("t1_br_signed", {31'd0, d1_br}, 32'd1);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0001, 1'b1);
        tick();
        check("t1_br_unsigned", {31'd0, d1_br}, 32'd0);
        idle();
        tick();
        check("t1_idle_valid", {31'd0, d1_valid}, 32'd0);
        check("t1_idle_br", {31'd0, d1_br}, 32'd0);
        check("t1_eval", {16'd0, d1_eval}, 32'd2);
        check("t1_taken", {16'd0, d1_taken}, 32'd1);

        // ---------------- op table: 1-stage and lagged 2-stage ----------------
        vecs[0]  = '{32'h8000_0000, 32'd0, 4'b0111, 1'b0, 1'b1};
        vecs[1]  = '{32'd0,         32'd0, 4'b1000, 1'b0, 1'b1};
        vecs[2]  = '{32'd0,         32'd0, 4'b1001, 1'b0, 1'b1};
        vecs[3]  = '{32'd1,         32'd0, 4'b1001, 1'b0, 1'b0};
        vecs[4]  = '{32'hFFFF_FFFF, 32'd0, 4'b1010, 1'b0, 1'b0};
        vecs[5]  = '{32'd1,         32'd0, 4'b1010, 1'b0, 1'b1};
        vecs[6]  = '{32'd2,         32'd2, 4'b0101, 1'b0, 1'b1};
        vecs[7]  = '{32'd3,         32'd2, 4'b0110, 1'b0, 1'b1};
        vecs[8]  = '{32'h8000_0000, 32'd1, 4'b0110, 1'b1, 1'b1};
        vecs[9]  = '{32'h8000_0000, 32'd1, 4'b0110, 1'b0, 1'b0};
        vecs[10] = '{32'd2,         32'd3, 4'b0010, 1'b1, 1'b1};
        vecs[11] = '{32'd7,         32'd7, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{32'd7,         32'd8, 4'b0100, 1'b0, 1'b1};
        vecs[13] = '{32'hFFFF_FFFF, 32'd0, 4'b0111, 1'b1, 1'b1};
        do_reset();
        exp_taken = 0;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].av, vecs[i].bv, vecs[i].opv, vecs[i].uv);
            tick();
            if (vecs[i].exp) exp_taken++;
            check($sformatf("vec%0d_d1_br", i), {31'd0, d1_br}, {31'd0, vecs[i].exp});
            if (i > 0) begin
                check($sformatf("vec%0d_d2_br", i - 1), {31'd0, d2_br}, {31'd0, vecs[i-1].exp});
            end
        end
        idle();
        tick();
        check("vec13_d2_br", {31'd0, d2_br}, {31'd0, vecs[13].exp});
        check("vec_d1_eval", {16'd0, d1_eval}, 32'd14);
        check("vec_d1_taken", {16'd0, d1_taken}, exp_taken);

        // ---------------- 2: 2-stage back-to-back ----------------
        do_reset();
        drive(1'b1, 32'd5, 32'd5, 4'b0011, 1'b0);
        tick();
        check("t2_c1_valid", {31'd0, d2_valid}, 32'd0);
        drive(1'b1, 32'd5, 32'd5, 4'b0100, 1'b0);
        tick();
        check("t2_c2_valid", {31'd0, d2_valid}, 32'd1);
        check("t2_c2_br", {31'd0, d2_br}, 32'd1);
        drive(1'b1, 32'd0, 32'd0, 4'b1010, 1'b0);
        tick();
        check("t2_c3_valid", {31'd0, d2_valid}, 32'd1);
        check("t2_c3_br", {31'd0, d2_br}, 32'd0);
        idle();
        tick();
        check("t2_c4_valid", {31'd0, d2_valid}, 32'd1);
        check("t2_c4_br", {31'd0, d2_br}, 32'd0);
        tick();
        check("t2_end_valid", {31'd0, d2_valid}, 32'd0);
        check("t2_eval", {16'd0, d2_eval}, 32'd3);
        check("t2_taken", {16'd0, d2_taken}, 32'd1);

        // ---------------- 3: stall ----------------
        do_reset();
        drive(1'b1, 32'd3, 32'd7, 4'b0001, 1'b0);
        tick();
        stall = 1'b1;
        drive(1'b1, 32'd9, 32'd9, 4'b0011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3_stall%0d_d2_valid", i), {31'd0, d2_valid}, 32'd0);
            check($sformatf("t3_stall%0d_d1_valid", i), {31'd0, d1_valid}, 32'd1);
            check($sformatf("t3_stall%0d_d1_br", i), {31'd0, d1_br}, 32'd1);
        end
        check("t3_stall_d1_eval", {16'd0, d1_eval}, 32'd0);
        stall = 1'b0;
        idle();
        tick();
        check("t3_rel_d2_valid", {31'd0, d2_valid}, 32'd1);
        check("t3_rel_d2_br", {31'd0, d2_br}, 32'd1);
        check("t3_rel_d1_eval", {16'd0, d1_eval}, 32'd1);
        tick();
        check("t3_after_d2_valid", {31'd0, d2_valid}, 32'd0);
        tick();
        check("t3_after2_d2_valid", {31'd0, d2_valid}, 32'd0);
        check("t3_d2_eval", {16'd0, d2_eval}, 32'd1);
        check("t3_d2_taken", {16'd0, d2_taken}, 32'd1);

        // ---------------- 4: flush ----------------
        do_reset();
        drive(1'b1, 32'd5, 32'd5, 4'b0011, 1'b0);
        tick();
        drive(1'b1, 32'd1, 32'd2, 4'b0001, 1'b0);
        tick();
        check("t4_pre_d2_valid", {31'd0, d2_valid}, 32'd1);
        flush = 1'b1;
        drive(1'b1, 32'd9, 32'd9, 4'b0011, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        check("t4_f0_d2_valid", {31'd0, d2_valid}, 32'd0);
        check("t4_f0_d2_br", {31'd0, d2_br}, 32'd0);
        check("t4_f0_d1_valid", {31'd0, d1_valid}, 32'd0);
        check("t4_f0_d2_eval", {16'd0, d2_eval}, 32'd1);
        check("t4_f0_d2_taken", {16'd0, d2_taken}, 32'd1);
        tick();
        check("t4_f1_d2_valid", {31'd0, d2_valid}, 32'd0);
        tick();
        check("t4_f2_d2_valid", {31'd0, d2_valid}, 32'd0);
        check("t4_d2_eval", {16'd0, d2_eval}, 32'd1);
        check("t4_d1_eval", {16'd0, d1_eval}, 32'd2);

        // ---------------- 5: counter saturation and clear ----------------
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'd0, 32'd1, 4'b0001, 1'b0);
            tick();
        end
        idle();
        tick();
        check("t5_sat_eval", {28'd0, d3_eval}, 32'd15);
        check("t5_sat_taken", {28'd0, d3_taken}, 32'd15);
        check("t5_wide_eval", {16'd0, d1_eval}, 32'd20);
        drive(1'b1, 32'd0, 32'd1, 4'b0001, 1'b0);
        tick();
        check("t5_clr_pre_valid", {31'd0, d3_valid}, 32'd1);
        idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t5_clr_eval", {28'd0, d3_eval}, 32'd0);
        check("t5_clr_taken", {28'd0, d3_taken}, 32'd0);

        // ---------------- 6: reset mid-stream, invalid op ----------------
        do_reset();
        drive(1'b1, 32'd1, 32'd1, 4'b0011, 1'b0);
        tick();
        tick();
        tick();
        check("t6_full_d2_valid", {31'd0, d2_valid}, 32'd1);
        do_reset();
        check("t6_rst_d2_valid", {31'd0, d2_valid}, 32'd0);
        check("t6_rst_d2_eval", {16'd0, d2_eval}, 32'd0);
        check("t6_rst_d2_taken", {16'd0, d2_taken}, 32'd0);
        drive(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0001, 1'b0);
        tick();
        check("t6_a1_d2_valid", {31'd0, d2_valid}, 32'd0);
        check("t6_a1_d1_br", {31'd0, d1_br}, 32'd1);
        drive(1'b1, 32'd4, 32'd4, 4'b1111, 1'b0);
        tick();
        check("t6_a2_d2_valid", {31'd0, d2_valid}, 32'd1);
        check("t6_a2_d2_br", {31'd0, d2_br}, 32'd1);
        check("t6_bad_d1_br", {31'd0, d1_br}, 32'd0);
        idle();
        tick();
        check("t6_bad_d2_valid", {31'd0, d2_valid}, 32'd1);
        check("t6_bad_d2_br", {31'd0, d2_br}, 32'd0);
        tick();
        check("t6_d2_eval", {16'd0, d2_eval}, 32'd2);
        check("t6_d2_taken", {16'd0, d2_taken}, 32'd1);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
